// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the pipeline: opcodes, load/store funct3
// encodings, access sizes and the memory-stage state encoding.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } mem_state_e;

    // Any funct3 outside the byte/half encodings is handled as a word access.
    function automatic mem_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the load/store stage: byte enables, store
// lane replication, load lane select with extension, and alignment fault.
module mem_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_lanes,
    output logic [31:0] o_rdata_ext,
    output logic        o_misaligned
);

    mem_size_e   w_size;
    logic        w_unsigned;
    logic [31:0] w_shifted;

    assign w_size     = f3_size(i_funct3);
    assign w_unsigned = i_funct3[2];
    assign w_shifted  = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be          = 4'b1111;
        o_wdata_lanes = i_wdata;
        o_rdata_ext   = i_rdata;
        o_misaligned  = 1'b0;
        case (w_size)
            SZ_B: begin
                o_be          = 4'b0001 << i_addr_lo;
                o_wdata_lanes = {4{i_wdata[7:0]}};
                o_rdata_ext   = {{24{w_shifted[7] & ~w_unsigned}}, w_shifted[7:0]};
            end
            SZ_H: begin
                o_be          = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_lanes = {2{i_wdata[15:0]}};
                o_rdata_ext   = {{16{w_shifted[15] & ~w_unsigned}}, w_shifted[15:0]};
                o_misaligned  = i_addr_lo[0];
            end
            default: begin
                o_misaligned = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Load/store stage between execute and write-back: passes ALU results through
// and runs the dbus request/ready handshake for aligned loads and stores.
module mem_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_flush,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_misaligned,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_data_wr,
    output logic [3:0]  dbus_be,
    output logic        dbus_rd,
    output logic        dbus_wr,
    input  logic [31:0] dbus_data_rd,
    input  logic        dbus_data_ready
);

    mem_state_e  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;
    logic        r_is_load;
    logic        r_kill;

    logic [2:0]  w_al_funct3;
    logic [1:0]  w_al_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lanes;
    logic [31:0] w_rdata_ext;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_is_mem;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_ready && in_valid && !in_flush;
    assign w_is_mem = in_is_load || in_is_store;

    // The aligner decodes the incoming op while idle and the captured op during the access.
    assign w_al_funct3  = (r_state == ST_IDLE) ? in_funct3    : r_funct3;
    assign w_al_addr_lo = (r_state == ST_IDLE) ? in_addr[1:0] : r_addr_lo;

    mem_align u_align (
        .i_funct3      (w_al_funct3),
        .i_addr_lo     (w_al_addr_lo),
        .i_wdata       (in_wdata),
        .i_rdata       (dbus_data_rd),
        .o_be          (w_be),
        .o_wdata_lanes (w_wdata_lanes),
        .o_rdata_ext   (w_rdata_ext),
        .o_misaligned  (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_funct3       <= 3'b000;
            r_addr_lo      <= 2'b00;
            r_rd           <= 5'd0;
            r_is_load      <= 1'b0;
            r_kill         <= 1'b0;
            out_valid      <= 1'b0;
            out_rd         <= 5'd0;
            out_data       <= 32'd0;
            out_misaligned <= 1'b0;
            dbus_addr      <= 32'd0;
            dbus_data_wr   <= 32'd0;
            dbus_be        <= 4'd0;
            dbus_rd        <= 1'b0;
            dbus_wr        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem) begin
                            out_valid      <= 1'b1;
                            out_data       <= in_addr;
                            out_rd         <= in_rd;
                            out_misaligned <= 1'b0;
                        end else if (w_misaligned) begin
                            out_valid      <= 1'b1;
                            out_data       <= in_addr;
                            out_rd         <= 5'd0;
                            out_misaligned <= 1'b1;
                        end else begin
                            dbus_addr    <= {in_addr[31:2], 2'b00};
                            dbus_be      <= w_be;
                            dbus_data_wr <= w_wdata_lanes;
                            dbus_rd      <= in_is_load;
                            dbus_wr      <= in_is_store;
                            r_funct3     <= in_funct3;
                            r_addr_lo    <= in_addr[1:0];
                            r_rd         <= in_is_load ? in_rd : 5'd0;
                            r_is_load    <= in_is_load;
                            r_kill       <= 1'b0;
                            r_state      <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // A flush cannot tear the access; it only drops the result.
                    if (in_flush) begin
                        r_kill <= 1'b1;
                    end
                    if (dbus_data_ready) begin
                        dbus_rd        <= 1'b0;
                        dbus_wr        <= 1'b0;
                        out_valid      <= !(r_kill || in_flush);
                        out_data       <= r_is_load ? w_rdata_ext : 32'd0;
                        out_rd         <= r_rd;
                        out_misaligned <= 1'b0;
                        r_state        <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a reference memory model predicts
// results, a bus responder serves dbus, and a monitor checks write-back output.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_flush, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid, out_misaligned;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [31:0] dbus_addr, dbus_data_wr, dbus_data_rd;
    logic [3:0]  dbus_be;
    logic        dbus_rd, dbus_wr, dbus_data_ready;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_flush(in_flush),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data),
        .out_misaligned(out_misaligned),
        .dbus_addr(dbus_addr), .dbus_data_wr(dbus_data_wr), .dbus_be(dbus_be),
        .dbus_rd(dbus_rd), .dbus_wr(dbus_wr),
        .dbus_data_rd(dbus_data_rd), .dbus_data_ready(dbus_data_ready)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        bit          chk_data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] bus_mem [int unsigned];
    int n_chk = 0;
    int n_pass = 0;
    bit resp_en = 1'b1;
    int force_waits = -1;

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_get(input int unsigned w);
        if (!ref_mem.exists(w)) ref_mem[w] = init_word(w);
        return ref_mem[w];
    endfunction

    function automatic logic [31:0] bus_get(input int unsigned w);
        if (!bus_mem.exists(w)) bus_mem[w] = init_word(w);
        return bus_mem[w];
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one op; expectations come from the reference memory and size rules.
    task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit kill);
        int          s   = size_of(f3);
        int          off = int'(a[1:0]);
        int unsigned w   = int'(a >> 2);
        bit          mem = ld || st;
        bit          mis = mem && ((off % s) != 0);
        logic [31:0] word, v;
        exp_t        e;
        bus_t        b;
        int          n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = a; in_wdata = wd; in_rd = rd;
        in_flush = kill && (!mem || mis);
        if (!mem || mis) begin
            e.rd = mis ? 5'd0 : rd; e.data = a; e.mis = mis; e.chk_data = 1'b1;
            if (!kill) exp_q.push_back(e);
        end else begin
            b.addr  = {a[31:2], 2'b00};
            b.be    = 4'(((1 << s) - 1) << off);
            b.wr    = st;
            b.wdata = (s == 1) ? {4{wd[7:0]}} : (s == 2) ? {2{wd[15:0]}} : wd;
            bus_q.push_back(b);
            word = ref_get(w);
            if (st) begin
                for (int i = 0; i < s; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
                ref_mem[w] = word;
                e.rd = 5'd0; e.data = 32'd0; e.mis = 1'b0; e.chk_data = 1'b0;
            end else begin
                v = word >> (8 * off);
                if (s == 1) v = f3[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
                else if (s == 2) v = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                e.rd = rd; e.data = v; e.mis = 1'b0; e.chk_data = 1'b1;
            end
            if (!kill) exp_q.push_back(e);
        end
        @(posedge clk); #1;
        if (!kill && (!mem || mis)) check("out_valid_latency", {31'b0, out_valid}, 32'd1);
        if (mem && !mis) check("strobe_latency", {30'b0, dbus_rd, dbus_wr}, {30'b0, ld, st});
        if (mis) check("no_strobe_misaligned", {30'b0, dbus_rd, dbus_wr}, 32'd0);
        in_valid = 1'b0; in_flush = 1'b0;
        if (kill && mem && !mis) begin
            in_flush = 1'b1;
            @(posedge clk); #1;
            in_flush = 1'b0;
        end
    endtask

    // Write-back monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
                    check("out_misaligned", {31'b0, out_misaligned}, {31'b0, e.mis});
                    if (e.chk_data) check("out_data", out_data, e.data);
                end
            end
        end
    end

    // Data bus responder with random wait states and noise on ready outside accesses
    initial begin
        bit          acc = 1'b0;
        int          waits = 0;
        int unsigned w;
        logic [31:0] word;
        bus_t        b;
        dbus_data_ready = 1'b0;
        dbus_data_rd    = 32'd0;
        forever begin
            @(negedge clk);
            if (resp_en && !reset && (dbus_rd || dbus_wr)) begin
                if (!acc) begin
                    acc = 1'b1;
                    waits = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
                    force_waits = -1;
                    if (bus_q.size() == 0) begin
                        check("unexpected_strobe", 32'd1, 32'd0);
                        b.addr = dbus_addr; b.be = dbus_be; b.wr = dbus_wr; b.wdata = dbus_data_wr;
                    end else begin
                        b = bus_q.pop_front();
                        check("dbus_wr", {31'b0, dbus_wr}, {31'b0, b.wr});
                        check("dbus_rd", {31'b0, dbus_rd}, {31'b0, ~b.wr});
                    end
                end
                check("dbus_addr", dbus_addr, b.addr);
                check("dbus_be", {28'b0, dbus_be}, {28'b0, b.be});
                if (b.wr) check("dbus_data_wr", dbus_data_wr, b.wdata);
                if (waits == 0) begin
                    dbus_data_ready = 1'b1;
                    w = int'(dbus_addr >> 2);
                    if (dbus_rd) begin
                        dbus_data_rd = bus_get(w);
                    end else begin
                        word = bus_get(w);
                        for (int i = 0; i < 4; i++)
                            if (dbus_be[i]) word[8*i +: 8] = dbus_data_wr[8*i +: 8];
                        bus_mem[w] = word;
                    end
                    acc = 1'b0;
                end else begin
                    dbus_data_ready = 1'b0;
                    dbus_data_rd    = $urandom;
                    waits--;
                end
            end else begin
                acc = 1'b0;
                dbus_data_ready = resp_en && ($urandom_range(0, 3) == 0);
                dbus_data_rd    = $urandom;
            end
        end
    end

    initial begin
        logic [2:0] ld_f3 [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        logic [2:0] st_f3 [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        int kind, n;
        reset = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_rd", {27'b0, out_rd}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_mis", {31'b0, out_misaligned}, 32'd0);
        check("rst_strobes", {30'b0, dbus_rd, dbus_wr}, 32'd0);
        check("rst_dbus_be", {28'b0, dbus_be}, 32'd0);
        check("rst_dbus_addr", dbus_addr, 32'd0);
        check("rst_dbus_wdata", dbus_data_wr, 32'd0);
        reset = 1'b0;

        ref_mem[32'h40] = 32'h80FF_0000; bus_mem[32'h40] = 32'h80FF_0000;
        ref_mem[32'h80] = 32'hBEEF_1234; bus_mem[32'h80] = 32'hBEEF_1234;
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 1'b0);
        force_waits = 2;
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 1'b0);
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'd0, 5'd8, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'd0, 5'd9, 1'b0);
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1122_33AB, 5'd10, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0402, 32'd0, 5'd11, 1'b0);
        force_waits = 3;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'hDEAD_BEEF, 5'd12, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 5'd13, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(1'b0, 1'b0, 3'b000, $urandom, 32'd0, 5'(i + 1), 1'b0);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 2)
                issue(1'b0, 1'b0, 3'(kind), $urandom, $urandom, 5'($urandom), $urandom_range(0, 9) == 0);
            else if (kind <= 6)
                issue(1'b1, 1'b0, ld_f3[$urandom_range(0, 6)], 32'h1000 + $urandom_range(0, 63),
                      32'd0, 5'($urandom), $urandom_range(0, 9) == 0);
            else
                issue(1'b0, 1'b1, st_f3[$urandom_range(0, 3)], 32'h1000 + $urandom_range(0, 63),
                      $urandom, 5'($urandom), $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end

        n = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0 || !in_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("bus_q_drained", bus_q.size(), 32'd0);

        // Reset in the middle of a store: strobe must fall and no result appear.
        resp_en = 1'b0;
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b1; in_funct3 = 3'b010;
        in_addr = 32'h0000_0600; in_wdata = 32'h0BAD_F00D; in_rd = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bus_held_before_reset", {31'b0, dbus_wr}, 32'd1);
        check("in_ready_low_in_bus", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_drops_strobe", {30'b0, dbus_rd, dbus_wr}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_no_out_valid", {31'b0, out_valid}, 32'd0);
        resp_en = 1'b1;
        issue(1'b0, 1'b0, 3'b000, 32'h0000_CAFE, 32'd0, 5'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
